seq_det_param: RTL and testbench

Parametrised serial pattern detector: compares a bit stream against a run-time programmable pattern of SEQ_LEN bits, with selectable overlapping or non-overlapping detection, input qualification, and a saturating match counter. It is the general-purpose successor to the fixed three-bit detectors. It sits between a serial data source and control or status logic that consumes one-cycle detect pulses and a running match count.

---
 rtl/seq_det_param.sv | 43 ++++
 tb/tb_seq_det_param.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seq_det_param.sv
// seq_det_param: programmable serial pattern detector with overlap control and saturating match count
module seq_det_param #(
    parameter int SEQ_LEN = 3,
    parameter int CNT_W = 8,
    localparam int FILL_W = $clog2(SEQ_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               seq_in,
    input  logic [SEQ_LEN-1:0] pattern,
    input  logic               overlap_en,
    input  logic               count_clr,
    output logic               detected,
    output logic [CNT_W-1:0]   match_count,
    output logic [FILL_W-1:0]  fill_out
);
    localparam logic [FILL_W-1:0] FULL = FILL_W'(SEQ_LEN);
    logic [SEQ_LEN-1:0] hist, cand;
    logic [FILL_W-1:0] fill, fill_inc, fill_nxt;
    logic match;
    always_comb begin
        cand = {hist[SEQ_LEN-2:0], seq_in};
        fill_inc = (fill == FULL) ? FULL : fill + 1'b1;
        match = in_valid && (fill_inc == FULL) && (cand == pattern);
        // non-overlapping mode demands SEQ_LEN fresh bits after every hit
        fill_nxt = !in_valid ? fill : (match && !overlap_en) ? '0 : fill_inc;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= '0;
            fill <= '0;
            detected <= 1'b0;
            match_count <= '0;
        end else begin
            if (in_valid) hist <= cand;
            fill <= fill_nxt;
            detected <= match;
            match_count <= count_clr ? '0 : (match && !(&match_count)) ? match_count + 1'b1 : match_count;
        end
    end
    assign fill_out = fill;
endmodule

// File: tb/tb_seq_det_param.sv
// tb_seq_det_param: table, directed and randomized checks of three seq_det_param configurations
module tb_seq_det_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, in_valid = 1'b0, seq_in = 1'b0, overlap_en = 1'b1, count_clr = 1'b0;
    logic [2:0] pat_a = 3'b101, pat_b = 3'b111;
    logic [7:0] pat_c = 8'hA5;
    logic det_a, det_b, det_c;
    logic [7:0] cnt_a, cnt_c;
    logic [1:0] cnt_b;
    logic [1:0] fill_a, fill_b;
    logic [3:0] fill_c;

    seq_det_param #(.SEQ_LEN(3), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .in_valid(in_valid), .seq_in(seq_in),
        .pattern(pat_a), .overlap_en(overlap_en), .count_clr(count_clr), .detected(det_a), .match_count(cnt_a), .fill_out(fill_a));
    seq_det_param #(.SEQ_LEN(3), .CNT_W(2)) dut_b (.clk(clk), .rst(rst), .in_valid(in_valid), .seq_in(seq_in),
        .pattern(pat_b), .overlap_en(overlap_en), .count_clr(count_clr), .detected(det_b), .match_count(cnt_b), .fill_out(fill_b));
    seq_det_param #(.SEQ_LEN(8), .CNT_W(8)) dut_c (.clk(clk), .rst(rst), .in_valid(in_valid), .seq_in(seq_in),
        .pattern(pat_c), .overlap_en(overlap_en), .count_clr(count_clr), .detected(det_c), .match_count(cnt_c), .fill_out(fill_c));

    int checks = 0, errors = 0;

    // reference model: all accepted bits since reset, plus per-config fresh-bit count
    bit acc[$];
    int lens[3] = '{3, 3, 8};
    longint cmax[3] = '{255, 3, 255};
    int fresh[3];
    longint mcnt[3];
    bit mdet[3];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit tail_match(int m, logic [31:0] p);
        for (int i = 0; i < lens[m]; i++)
            if (acc[acc.size() - 1 - i] != p[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge();
        logic [31:0] p[3];
        bit mt;
        p[0] = 32'(pat_a); p[1] = 32'(pat_b); p[2] = 32'(pat_c);
        if (rst) begin
            acc.delete();
            for (int m = 0; m < 3; m++) begin fresh[m] = 0; mcnt[m] = 0; mdet[m] = 0; end
        end else begin
            if (in_valid) begin
                acc.push_back(seq_in);
                if (acc.size() > 64) void'(acc.pop_front());
            end
            for (int m = 0; m < 3; m++) begin
                mt = 0;
                if (in_valid) begin
                    if (fresh[m] < lens[m]) fresh[m]++;
                    mt = (fresh[m] == lens[m]) && tail_match(m, p[m]);
                    if (mt && !overlap_en) fresh[m] = 0;
                end
                mdet[m] = mt;
                if (count_clr) mcnt[m] = 0;
                else if (mt && mcnt[m] < cmax[m]) mcnt[m]++;
            end
        end
    endtask

    task automatic tick();
        logic [63:0] ad[3], ac[3], af[3];
        @(posedge clk);
        model_edge();
        #1;
        ad = '{64'(det_a), 64'(det_b), 64'(det_c)};
        ac = '{64'(cnt_a), 64'(cnt_b), 64'(cnt_c)};
        af = '{64'(fill_a), 64'(fill_b), 64'(fill_c)};
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("model_det[%0d] t=%0t", m, $time), ad[m], 64'(mdet[m]));
            chk($sformatf("model_cnt[%0d] t=%0t", m, $time), ac[m], 64'(mcnt[m]));
            chk($sformatf("model_fill[%0d] t=%0t", m, $time), af[m], 64'(fresh[m]));
        end
    endtask

    task automatic feed(bit b);
        rst = 0; in_valid = 1; seq_in = b; count_clr = 0;
        tick();
    endtask

    task automatic do_rst();
        rst = 1; in_valid = 0; seq_in = 0; count_clr = 0;
        tick();
        rst = 0;
    endtask

    typedef struct {
        bit rst, vld, b, ov;
        bit exp_det;
        int exp_cnt, exp_fill;
    } vec_t;
    vec_t tv[$];

    initial begin
        logic [7:0] a5;
        a5 = 8'hA5;
        // expectations for dut_a (SEQ_LEN=3, pattern 101)
        tv = '{
            '{1,0,0,1, 0,0,0},
            '{0,1,1,1, 0,0,1}, '{0,1,0,1, 0,0,2}, '{0,1,1,1, 1,1,3}, '{0,1,0,1, 0,1,3}, '{0,1,1,1, 1,2,3},
            '{1,0,0,0, 0,0,0},
            '{0,1,1,0, 0,0,1}, '{0,1,0,0, 0,0,2}, '{0,1,1,0, 1,1,0}, '{0,1,1,0, 0,1,1}, '{0,1,0,0, 0,1,2}, '{0,1,1,0, 1,2,0},
            '{1,0,0,0, 0,0,0},
            '{0,1,1,0, 0,0,1}, '{0,1,0,0, 0,0,2}, '{0,1,1,0, 1,1,0}, '{0,1,0,0, 0,1,1}, '{0,1,1,0, 0,1,2},
            '{1,0,0,1, 0,0,0},
            '{0,1,1,1, 0,0,1}, '{0,0,0,1, 0,0,1}, '{0,0,0,1, 0,0,1}, '{0,0,0,1, 0,0,1}, '{0,0,0,1, 0,0,1},
            '{0,1,0,1, 0,0,2}, '{0,1,1,1, 1,1,3}
        };
        foreach (tv[i]) begin
            rst = tv[i].rst; in_valid = tv[i].vld; seq_in = tv[i].b; overlap_en = tv[i].ov; count_clr = 0;
            tick();
            chk($sformatf("tbl_det[%0d]", i), 64'(det_a), 64'(tv[i].exp_det));
            chk($sformatf("tbl_cnt[%0d]", i), 64'(cnt_a), 64'(tv[i].exp_cnt));
            chk($sformatf("tbl_fill[%0d]", i), 64'(fill_a), 64'(tv[i].exp_fill));
        end

        // saturation on a 2-bit counter, then clear racing a match
        overlap_en = 1; pat_b = 3'b111;
        do_rst();
        for (int i = 0; i < 6; i++) begin
            feed(1);
            chk($sformatf("sat_det[%0d]", i), 64'(det_b), 64'(i >= 2));
            chk($sformatf("sat_cnt[%0d]", i), 64'(cnt_b), 64'(i < 2 ? 0 : (i - 1 > 3 ? 3 : i - 1)));
        end
        rst = 0; in_valid = 1; seq_in = 1; count_clr = 1;
        tick();
        count_clr = 0;
        chk("clr_vs_match_det", 64'(det_b), 64'd1);
        chk("clr_vs_match_cnt", 64'(cnt_b), 64'd0);

        // 8-bit pattern, reset mid-sequence, fresh pattern afterwards
        overlap_en = 0; pat_c = 8'hA5;
        do_rst();
        for (int i = 7; i >= 0; i--) begin
            feed(a5[i]);
            chk($sformatf("a5_det[%0d]", i), 64'(det_c), 64'(i == 0));
        end
        chk("a5_cnt", 64'(cnt_c), 64'd1);
        for (int i = 7; i >= 3; i--) feed(a5[i]);
        do_rst();
        chk("mid_rst_det", 64'(det_c), 64'd0);
        chk("mid_rst_cnt", 64'(cnt_c), 64'd0);
        chk("mid_rst_fill", 64'(fill_c), 64'd0);
        for (int i = 7; i >= 0; i--) begin
            feed(a5[i]);
            chk($sformatf("a5b_det[%0d]", i), 64'(det_c), 64'(i == 0));
        end

        // live pattern change against stale history
        overlap_en = 1; pat_a = 3'b101;
        do_rst();
        feed(0); feed(1);
        chk("pchg_fill", 64'(fill_a), 64'd2);
        pat_a = 3'b011;
        feed(1);
        chk("pchg_det", 64'(det_a), 64'd1);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            seq_in = ($urandom_range(0, 4) == 0) ? ~seq_in : seq_in;
            if ($urandom_range(0, 3) == 0) seq_in = 1'($urandom);
            count_clr = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 49) == 0) overlap_en = 1'($urandom);
            if ($urandom_range(0, 49) == 0) pat_a = 3'($urandom);
            if ($urandom_range(0, 49) == 0) pat_b = $urandom_range(0, 1) ? 3'b111 : 3'($urandom);
            if ($urandom_range(0, 99) == 0) pat_c = $urandom_range(0, 1) ? ($urandom_range(0, 1) ? 8'hFF : 8'h00) : 8'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
